full_hk_wclk: RTL and testbench
===============================

FULL_HK_WCLK -- requirements
Module: full_hk_wclk

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, setting the payload width in bits.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, minimum 2, setting the rd_ack synchronizer depth.
REQ-003 The module SHALL have parameter CNT_W, default 16, setting the transfer counter width.
REQ-004 The module SHALL have port clk, input, 1, the write-domain clock; all flops SHALL sit on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-006 The module SHALL have port src_vld, input, 1, meaning the local source offers a word.
REQ-007 The module SHALL have port src_data, input, DATA_W, the offered word.
REQ-008 The module SHALL have port src_rdy, output, 1, meaning the block can accept a word this cycle.
REQ-009 The module SHALL have port wr_vld, output, 1, the 4-phase request to the read-clock handshake stage.
REQ-010 The module SHALL have port wr_data, output, DATA_W, the payload held for the read domain.
REQ-011 The module SHALL have port rd_ack, input, 1, the acknowledge from the read domain, asynchronous to clk.
REQ-012 The module SHALL have port xfer_done, output, 1, a one-cycle pulse when a full 4-phase cycle completes.
REQ-013 The module SHALL have port xfer_cnt, output, CNT_W, the count of completed transfers.
REQ-014 The module SHALL have port proto_err, output, 1, a sticky flag for an acknowledge protocol violation.

Function
REQ-015 rd_ack SHALL pass through a SYNC_STAGES flop chain; only the last stage (ack_s) SHALL be used by the FSM.
REQ-016 The FSM SHALL have states IDLE, REQ, and DROP, with IDLE as the reset state.
REQ-017 In IDLE, src_rdy SHALL be 1; in REQ and DROP, src_rdy SHALL be 0.
REQ-018 In IDLE, when src_vld=1, the block SHALL capture src_data into wr_data and move to REQ.
REQ-019 wr_vld SHALL be registered: 1 exactly while the state is REQ, rising the cycle after acceptance.
REQ-020 In REQ, when ack_s=1, the FSM SHALL move to DROP, so wr_vld falls on the next edge.
REQ-021 In DROP, when ack_s=0, the FSM SHALL move to IDLE and assert xfer_done for that one cycle.
REQ-022 When xfer_done is asserted, xfer_cnt SHALL increment by 1, wrapping modulo 2^CNT_W.
REQ-023 wr_data SHALL hold stable from capture until the FSM returns to IDLE, and SHALL change only on acceptance.
REQ-024 A new word SHALL be acceptable in the same cycle the FSM is in IDLE after xfer_done; there is no extra bubble.
REQ-025 Minimum transfer period SHALL be 1 + 2*(SYNC_STAGES+1) + read-side latency cycles.
REQ-026 If ack_s=1 while in IDLE, proto_err SHALL set and hold until reset, and src_rdy SHALL stay 0 until ack_s returns to 0.
REQ-027 src_vld with src_rdy=0 SHALL be ignored, and src_data SHALL be ignored; no internal queueing SHALL occur.
REQ-028 Glitches on rd_ack shorter than one clk period SHALL NOT be required to be observed; only level changes held at least SYNC_STAGES cycles are guaranteed.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, wr_vld=0, wr_data=0, xfer_done=0, xfer_cnt=0, proto_err=0, and all synchronizer flops=0.
REQ-030 src_rdy SHALL be 1 during and after reset, combinationally from IDLE with ack_s=0.
REQ-031 Reset asserted mid-transfer SHALL abort it with no xfer_done pulse; the read side is reset by the same rst_n.

Structure
REQ-032 The FSM state enum (IDLE, REQ, DROP) and the default widths SHALL live in a shared package full_hk_pkg, shared with the read-side block.
REQ-033 The synchronizer SHALL be a separate sub-module, hk_sync, parameterized by SYNC_STAGES, reusable by the read side.
REQ-034 The top SHALL contain only the FSM, data register, counter, and error flag; all outputs except src_rdy SHALL be registered.

Verification
REQ-035 Reset, src_vld=1, src_data=8'hA5, with read side ack 1 cycle after wr_vld: wr_vld rises 1 cycle after accept, wr_data=8'hA5, xfer_done pulses once, xfer_cnt=1.
REQ-036 src_vld held high with words 8'h01..8'h05 back-to-back: exactly 5 transfers occur in order, wr_data never changes while wr_vld=1, and xfer_cnt=5.
REQ-037 rd_ack forced high in IDLE for 4 cycles: proto_err=1 sticky, src_rdy=0 until ack_s=0, and no transfer starts.
REQ-038 rst_n pulsed low while in REQ: all outputs return to reset values immediately, with no xfer_done.
REQ-039 CNT_W=4, run 17 transfers: xfer_cnt reads 4'h1 after wrap.
REQ-040 Read side withholds rd_ack for 100 cycles: wr_vld stays 1 and wr_data stays constant throughout, and src_rdy=0.

Source files
------------

// File: rtl/full_hk_pkg.sv
// Shared definitions for the write- and read-clock sides of the 4-phase handshake.
package full_hk_pkg;

   localparam int unsigned DefDataW      = 8;
   localparam int unsigned DefSyncStages = 2;
   localparam int unsigned DefCntW       = 16;

   typedef logic [1:0] hk_state_t;

   localparam hk_state_t StIdle = 2'd0;
   localparam hk_state_t StReq  = 2'd1;
   localparam hk_state_t StDrop = 2'd2;

endpackage

// File: rtl/hk_sync.sv
// Multi-flop level synchronizer for a single handshake bit crossing into the clk domain.
module hk_sync
   import full_hk_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/full_hk_wclk.sv
// Write-clock side of a 4-phase request/acknowledge crossing: accepts one word, holds it
// on wr_data while wr_vld runs the handshake, and counts completed transfers.
module full_hk_wclk
   import full_hk_pkg::*;
#(
   parameter int unsigned DATA_W      = DefDataW,
   parameter int unsigned SYNC_STAGES = DefSyncStages,
   parameter int unsigned CNT_W       = DefCntW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              src_vld,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_rdy,
   output logic              wr_vld,
   output logic [DATA_W-1:0] wr_data,
   input  logic              rd_ack,
   output logic              xfer_done,
   output logic [CNT_W-1:0]  xfer_cnt,
   output logic              proto_err
);

   logic      ack_s;
   logic      accept;
   logic      done_d;
   hk_state_t state_q, state_d;

   hk_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ack_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rd_ack),
      .q    (ack_s)
   );

   // A stale acknowledge in IDLE blocks new words until the read side releases it.
   assign src_rdy = (state_q == StIdle) && !ack_s;
   assign accept  = src_vld && src_rdy;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: if (accept) state_d = StReq;
         StReq:  if (ack_s)  state_d = StDrop;
         StDrop: begin
            if (!ack_s) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         wr_vld    <= 1'b0;
         wr_data   <= '0;
         xfer_done <= 1'b0;
         xfer_cnt  <= '0;
         proto_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_vld    <= (state_d == StReq);
         xfer_done <= done_d;
         if (accept) begin
            wr_data <= src_data;
         end
         if (done_d) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
         if ((state_q == StIdle) && ack_s) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_full_hk_wclk.sv
// Bench for full_hk_wclk: cycle table for the forced-ack cases, then a 4-phase read-side
// responder with a transfer scoreboard for back-to-back, stall, reset, wrap and random traffic.
module tb_full_hk_wclk;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          src_vld;
   logic [DW-1:0] src_data;
   logic          src_rdy;
   logic          wr_vld;
   logic [DW-1:0] wr_data;
   logic          rd_ack;
   logic          xfer_done;
   logic [CW-1:0] xfer_cnt;
   logic          proto_err;

   logic force_en;
   logic force_val;
   logic auto_ack;
   int   ack_delay;
   int   dly;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] sent_q[$];
   int            n_done;
   logic          mon_en;

   full_hk_wclk #(
      .DATA_W     (DW),
      .SYNC_STAGES(2),
      .CNT_W      (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_vld  (src_vld),
      .src_data (src_data),
      .src_rdy  (src_rdy),
      .wr_vld   (wr_vld),
      .wr_data  (wr_data),
      .rd_ack   (rd_ack),
      .xfer_done(xfer_done),
      .xfer_cnt (xfer_cnt),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   assign rd_ack = force_en ? force_val : auto_ack;

   // Read side: ack follows wr_vld (both phases) after ack_delay cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto_ack <= 1'b0;
         dly      <= 0;
      end else if (wr_vld != auto_ack) begin
         if (dly >= ack_delay) begin
            auto_ack <= wr_vld;
            dly      <= 0;
         end else begin
            dly <= dly + 1;
         end
      end else begin
         dly <= 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: each wr_vld rise must present the next accepted word; it must then hold.
   initial begin
      logic          prev_vld;
      logic [DW-1:0] held;
      logic [DW-1:0] exp;
      prev_vld = 1'b0;
      held     = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mon_en) begin
            if (xfer_done) n_done++;
            if (wr_vld && !prev_vld) begin
               if (sent_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL wr_vld_rise_without_accept: got data %0h expected none", wr_data);
               end else begin
                  exp = sent_q.pop_front();
                  check("wr_data_order", 32'(wr_data), 32'(exp));
               end
               held = wr_data;
            end else if (wr_vld) begin
               check("wr_data_stable", 32'(wr_data), 32'(held));
            end
            prev_vld = wr_vld;
         end else begin
            prev_vld = 1'b0;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_src_rdy"},   32'(src_rdy),   32'd1);
      check({tag, "_wr_vld"},    32'(wr_vld),    32'd0);
      check({tag, "_wr_data"},   32'(wr_data),   32'd0);
      check({tag, "_xfer_done"}, 32'(xfer_done), 32'd0);
      check({tag, "_xfer_cnt"},  32'(xfer_cnt),  32'd0);
      check({tag, "_proto_err"}, 32'(proto_err), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst");
      sent_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Offer a word until accepted; wr_vld must be high right after the accepting edge.
   task automatic send(input logic [DW-1:0] d, input int budget, input bit hold);
      bit accepted;
      accepted = 1'b0;
      @(negedge clk);
      src_vld  = 1'b1;
      src_data = d;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (src_rdy) begin
            sent_q.push_back(d);
            accepted = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept for %0h expected accept within %0d", d, budget);
      end else begin
         @(posedge clk);
         #1;
         check("wr_vld_after_accept", 32'(wr_vld), 32'd1);
      end
      if (!hold) begin
         @(negedge clk);
         src_vld = 1'b0;
      end
   endtask

   task automatic wait_idle(input int budget);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (src_rdy && !wr_vld && !rd_ack) begin
            idle = 1'b1;
            break;
         end
      end
      #2;
      if (!idle) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy expected idle within %0d cycles", budget);
      end
   endtask

   typedef struct {
      logic          vld;
      logic [DW-1:0] data;
      logic          ack;
      logic          rdy;
      logic          wv;
      logic [DW-1:0] wd;
      logic          done;
      logic [CW-1:0] cnt;
      logic          perr;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic a,
                               input logic r, input logic wv, input logic [DW-1:0] wd,
                               input logic dn, input logic [CW-1:0] c, input logic pe);
      vec_t t;
      t.vld = v;  t.data = d;  t.ack = a;
      t.rdy = r;  t.wv = wv;   t.wd = wd;
      t.done = dn; t.cnt = c;  t.perr = pe;
      return t;
   endfunction

   initial begin
      vec_t tbl[15];
      int   gap;
      int   n_rand;

      // One forced transfer of A5 (ack seen 2 cycles late through the synchronizer),
      // then ack held high in IDLE for 4 cycles with src_vld offered.
      tbl[0]  = mk(1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0, 0);
      tbl[1]  = mk(0, 8'h00, 1, 0, 1, 8'hA5, 0, 0, 0);
      tbl[2]  = mk(0, 8'h00, 1, 0, 1, 8'hA5, 0, 0, 0);
      tbl[3]  = mk(0, 8'h00, 1, 0, 0, 8'hA5, 0, 0, 0);
      tbl[4]  = mk(0, 8'h00, 0, 0, 0, 8'hA5, 0, 0, 0);
      tbl[5]  = mk(0, 8'h00, 0, 0, 0, 8'hA5, 0, 0, 0);
      tbl[6]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 1, 1, 0);
      tbl[7]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 0, 1, 0);
      tbl[8]  = mk(0, 8'h00, 1, 1, 0, 8'hA5, 0, 1, 0);
      tbl[9]  = mk(0, 8'h00, 1, 0, 0, 8'hA5, 0, 1, 0);
      tbl[10] = mk(1, 8'h5A, 1, 0, 0, 8'hA5, 0, 1, 1);
      tbl[11] = mk(1, 8'h5A, 1, 0, 0, 8'hA5, 0, 1, 1);
      tbl[12] = mk(1, 8'h5A, 0, 0, 0, 8'hA5, 0, 1, 1);
      tbl[13] = mk(1, 8'h5A, 0, 1, 0, 8'hA5, 0, 1, 1);
      tbl[14] = mk(0, 8'h5A, 0, 1, 0, 8'hA5, 0, 1, 1);

      rst_n     = 1'b0;
      src_vld   = 1'b0;
      src_data  = '0;
      force_en  = 1'b1;
      force_val = 1'b0;
      ack_delay = 0;
      mon_en    = 1'b0;
      n_done    = 0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         src_vld   = tbl[i].vld;
         src_data  = tbl[i].data;
         force_val = tbl[i].ack;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_src_rdy", i),   32'(src_rdy),   32'(tbl[i].rdy));
         check($sformatf("tbl%0d_wr_vld", i),    32'(wr_vld),    32'(tbl[i].wv));
         check($sformatf("tbl%0d_wr_data", i),   32'(wr_data),   32'(tbl[i].wd));
         check($sformatf("tbl%0d_xfer_done", i), 32'(xfer_done), 32'(tbl[i].done));
         check($sformatf("tbl%0d_xfer_cnt", i),  32'(xfer_cnt),  32'(tbl[i].cnt));
         check($sformatf("tbl%0d_proto_err", i), 32'(proto_err), 32'(tbl[i].perr));
      end
      @(negedge clk);
      src_vld   = 1'b0;
      force_val = 1'b0;
      do_reset();
      force_en = 1'b0;
      mon_en   = 1'b1;

      // Back-to-back words 01..05 with src_vld held high.
      ack_delay = 0;
      n_done    = 0;
      for (int k = 1; k <= 5; k++) send(DW'(k), 50, 1'b1);
      @(negedge clk);
      src_vld = 1'b0;
      wait_idle(100);
      check("b2b_done_count", 32'(n_done), 32'd5);
      check("b2b_xfer_cnt", 32'(xfer_cnt), 32'd5);
      check("b2b_queue_empty", 32'(sent_q.size()), 32'd0);

      // Read side stalls the acknowledge for over 100 cycles.
      ack_delay = 110;
      send(8'h3C, 50, 1'b0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("stall_wr_vld", 32'(wr_vld), 32'd1);
         check("stall_wr_data", 32'(wr_data), 32'h3C);
         check("stall_src_rdy", 32'(src_rdy), 32'd0);
      end
      wait_idle(300);
      check("stall_done_count", 32'(n_done), 32'd6);
      check("stall_xfer_cnt", 32'(xfer_cnt), 32'd6);

      // Reset in the middle of a request aborts it without a done pulse.
      ack_delay = 40;
      send(8'hC3, 50, 1'b0);
      repeat (3) @(negedge clk);
      check("abort_in_req", 32'(wr_vld), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(xfer_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sent_q.delete();
      repeat (2) @(negedge clk);
      check("abort_done_count", 32'(n_done), 32'd6);
      check("abort_xfer_cnt", 32'(xfer_cnt), 32'd0);

      // 17 transfers with a 4-bit counter wrap to 1.
      ack_delay = 0;
      n_done    = 0;
      for (int k = 0; k < 17; k++) send(DW'(8'h80 + k), 50, 1'b0);
      wait_idle(100);
      check("wrap_done_count", 32'(n_done), 32'd17);
      check("wrap_xfer_cnt", 32'(xfer_cnt), 32'd1);

      // Random words, gaps and read-side latencies.
      n_done = 0;
      n_rand = 30;
      for (int k = 0; k < n_rand; k++) begin
         ack_delay = int'($urandom_range(0, 6));
         send(DW'($urandom), 200, 1'b1);
         gap = int'($urandom_range(0, 3));
         if (gap != 0) begin
            @(negedge clk);
            src_vld = 1'b0;
            repeat (gap - 1) @(negedge clk);
         end
      end
      @(negedge clk);
      src_vld = 1'b0;
      wait_idle(200);
      check("rand_done_count", 32'(n_done), 32'(n_rand));
      check("rand_xfer_cnt", 32'(xfer_cnt), 32'((1 + n_rand) % (1 << CW)));
      check("rand_queue_empty", 32'(sent_q.size()), 32'd0);
      check("rand_no_proto_err", 32'(proto_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1000000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
